// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard stall/flush controller and its neighbours.
package hazard_stall_unit_pkg;

    localparam int PIPE_REG_W = 5;

    // Canonical NOP that the flush and bubble muxes load into IF/ID and ID/EX.
    localparam logic [31:0] PIPE_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_DIV_BUSY = 2'd2,
        HZ_ILLEGAL  = 2'd3
    } hz_state_t;

endpackage

// File: rtl/hazard_stall_unit_div_counter.sv
// Loadable down-counter with a zero flag; also reused by the divider datapath.
module hz_div_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Counter register: load wins over decrement, and it saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use, memory wait states,
// multi-cycle divide and taken-branch flush (deferred while the pipe is frozen).
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_W      = PIPE_REG_W,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_div_start,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             div_done,
    output logic [1:0]       hz_state
);

    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    hz_state_t        state_r;
    logic             flush_pend_r;
    logic [CNT_W-1:0] div_cnt_s;
    logic             div_zero_s;
    logic             mem_stall_s;
    logic             freeze_s;
    logic             load_use_s;
    logic             div_load_s;
    logic             div_dec_s;

    assign mem_stall_s = mem_req & ~mem_ready;

    assign freeze_s = (state_r == HZ_MEM_WAIT) | (state_r == HZ_DIV_BUSY) |
                      ((state_r == HZ_RUN) & mem_stall_s) |
                      ((state_r == HZ_RUN) & ex_div_start);

    assign load_use_s = ex_is_load & (ex_rd != {REG_W{1'b0}}) &
                        ((id_uses_rs & (rs_id == ex_rd)) | (id_uses_rt & (rt_id == ex_rd)));

    // A memory stall in the same cycle keeps the divide parked in EX, so only load when it is clear.
    assign div_load_s = (state_r == HZ_RUN) & ex_div_start & ~mem_stall_s;
    assign div_dec_s  = (state_r == HZ_DIV_BUSY) & ~div_zero_s;

    hz_div_counter #(
        .CNT_W (CNT_W)
    ) u_div_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load_s),
        .load_val (DIV_LOAD),
        .dec      (div_dec_s),
        .cnt      (div_cnt_s),
        .zero     (div_zero_s)
    );

    // FSM and deferred-flush register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= HZ_RUN;
            flush_pend_r <= 1'b0;
        end else begin
            if (freeze_s && ex_branch_taken) begin
                flush_pend_r <= 1'b1;
            end else if (!freeze_s) begin
                flush_pend_r <= 1'b0;
            end else begin
                flush_pend_r <= flush_pend_r;
            end

            case (state_r)
                HZ_RUN: begin
                    if (mem_stall_s) begin
                        state_r <= HZ_MEM_WAIT;
                    end else if (ex_div_start) begin
                        state_r <= HZ_DIV_BUSY;
                    end else begin
                        state_r <= HZ_RUN;
                    end
                end
                HZ_MEM_WAIT: begin
                    if (mem_ready) begin
                        state_r <= HZ_RUN;
                    end else begin
                        state_r <= HZ_MEM_WAIT;
                    end
                end
                HZ_DIV_BUSY: begin
                    if (div_zero_s) begin
                        state_r <= HZ_RUN;
                    end else begin
                        state_r <= HZ_DIV_BUSY;
                    end
                end
                default: state_r <= HZ_RUN;
            endcase
        end
    end

    // Enable / flush / bubble decode; priority freeze > flush > load-use.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        div_done    = 1'b0;
        if (rst) begin
            pc_en = 1'b1;
        end else if (freeze_s) begin
            case (state_r)
                HZ_MEM_WAIT: begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
                end
                HZ_DIV_BUSY: begin
                    if (div_zero_s) begin
                        div_done = 1'b1;
                    end else begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00001;
                    end
                end
                HZ_RUN: begin
                    if (mem_stall_s) begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
                    end else begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00001;
                    end
                end
                default: begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                end
            endcase
        end else if (ex_branch_taken || flush_pend_r) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use_s) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            pc_en = 1'b1;
        end
    end

    assign hz_state = rst ? 2'd0 : state_r;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit with a 4-cycle divide.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_id, rt_id, ex_rd;
    logic       id_uses_rs, id_uses_rt, ex_is_load, ex_div_start;
    logic       ex_branch_taken, mem_req, mem_ready;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_bubble, div_done;
    logic [1:0] hz_state;

    int errors = 0;
    int checks = 0;

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_bubble, div_done}
    localparam logic [7:0] C_ALL   = 8'b11111_000;
    localparam logic [7:0] C_LU    = 8'b00111_010;
    localparam logic [7:0] C_FLUSH = 8'b11111_110;
    localparam logic [7:0] C_FROZE = 8'b00000_000;
    localparam logic [7:0] C_DIV   = 8'b00001_000;
    localparam logic [7:0] C_DONE  = 8'b11111_001;

    hazard_stall_unit #(
        .REG_W      (5),
        .DIV_CYCLES (4),
        .CNT_W      (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rs_id           (rs_id),
        .rt_id           (rt_id),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_rd           (ex_rd),
        .ex_is_load      (ex_is_load),
        .ex_div_start    (ex_div_start),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .div_done        (div_done),
        .hz_state        (hz_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are already set; check on the falling edge, then advance one clock.
    task automatic cyc(input string tag, input logic [7:0] exp_ctl, input logic [1:0] exp_st);
        @(negedge clk);
        check({tag, ".ctl"}, {24'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                              ifid_flush, idex_bubble, div_done}, {24'd0, exp_ctl});
        check({tag, ".st"}, {30'd0, hz_state}, {30'd0, exp_st});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        rs_id = 5'd0; rt_id = 5'd0; ex_rd = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_is_load = 1'b0;
        ex_div_start = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        idle();
        // Reset overrides every hazard input.
        rst = 1'b1; mem_req = 1'b1; ex_div_start = 1'b1; ex_branch_taken = 1'b1;
        cyc("reset_hold", C_ALL, 2'd0);
        idle();
        cyc("after_reset", C_ALL, 2'd0);

        // Load-use on rs, then released.
        ex_is_load = 1'b1; ex_rd = 5'd8; rs_id = 5'd8; id_uses_rs = 1'b1;
        cyc("lu_rs", C_LU, 2'd0);
        ex_is_load = 1'b0;
        cyc("lu_release", C_ALL, 2'd0);
        // Load-use on rt.
        ex_is_load = 1'b1; ex_rd = 5'd8; rs_id = 5'd3; rt_id = 5'd8; id_uses_rt = 1'b1;
        cyc("lu_rt", C_LU, 2'd0);
        // Register zero never stalls.
        idle(); ex_is_load = 1'b1; ex_rd = 5'd0; rs_id = 5'd0; id_uses_rs = 1'b1;
        cyc("lu_zero", C_ALL, 2'd0);
        // Matching rt but not used.
        idle(); ex_is_load = 1'b1; ex_rd = 5'd8; rs_id = 5'd3; id_uses_rs = 1'b1; rt_id = 5'd8;
        cyc("lu_rt_unused", C_ALL, 2'd0);

        // Memory wait: 3 not-ready cycles then ready.
        idle(); mem_req = 1'b1;
        cyc("mw0", C_FROZE, 2'd0);
        ex_is_load = 1'b1; ex_rd = 5'd8; rs_id = 5'd8; id_uses_rs = 1'b1;
        cyc("mw1", C_FROZE, 2'd1);
        cyc("mw2", C_FROZE, 2'd1);
        mem_ready = 1'b1;
        cyc("mw3_ready", C_FROZE, 2'd1);
        idle();
        cyc("mw_exit", C_ALL, 2'd0);

        // Divide with DIV_CYCLES=4; a stray mem_req while busy is ignored.
        ex_div_start = 1'b1;
        cyc("div0", C_DIV, 2'd0);
        ex_div_start = 1'b0; mem_req = 1'b1;
        cyc("div1", C_DIV, 2'd2);
        mem_req = 1'b0;
        cyc("div2", C_DIV, 2'd2);
        cyc("div3_done", C_DONE, 2'd2);
        cyc("div_exit", C_ALL, 2'd0);

        // Branch taken during divide is deferred until after div_done.
        ex_div_start = 1'b1;
        cyc("dfl0", C_DIV, 2'd0);
        ex_div_start = 1'b0; ex_branch_taken = 1'b1;
        cyc("dfl1_branch", C_DIV, 2'd2);
        ex_branch_taken = 1'b0;
        cyc("dfl2", C_DIV, 2'd2);
        cyc("dfl3_done", C_DONE, 2'd2);
        cyc("dfl_apply", C_FLUSH, 2'd0);
        cyc("dfl_cleared", C_ALL, 2'd0);

        // Immediate flush beats load-use.
        ex_branch_taken = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd4; rt_id = 5'd4; id_uses_rt = 1'b1;
        cyc("flush_over_lu", C_FLUSH, 2'd0);
        idle();
        cyc("flush_once", C_ALL, 2'd0);

        // Memory stall and divide together: wait first, divide re-seen afterwards.
        mem_req = 1'b1; ex_div_start = 1'b1;
        cyc("md0", C_FROZE, 2'd0);
        mem_ready = 1'b1;
        cyc("md1_ready", C_FROZE, 2'd1);
        mem_req = 1'b0; mem_ready = 1'b0;
        cyc("md2_divstart", C_DIV, 2'd0);
        ex_div_start = 1'b0;
        cyc("md3", C_DIV, 2'd2);
        cyc("md4", C_DIV, 2'd2);
        cyc("md5_done", C_DONE, 2'd2);

        // Reset during MEM_WAIT with a branch pending: no flush survives.
        idle(); mem_req = 1'b1;
        cyc("rmw0", C_FROZE, 2'd0);
        ex_branch_taken = 1'b1;
        cyc("rmw1_branch", C_FROZE, 2'd1);
        rst = 1'b1;
        cyc("rmw_rst", C_ALL, 2'd0);
        idle();
        cyc("rmw_after", C_ALL, 2'd0);

        // Reset during DIV_BUSY: no div_done afterwards.
        ex_div_start = 1'b1;
        cyc("rdv0", C_DIV, 2'd0);
        ex_div_start = 1'b0;
        cyc("rdv1", C_DIV, 2'd2);
        rst = 1'b1;
        cyc("rdv_rst", C_ALL, 2'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc("rdv_quiet", C_ALL, 2'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline stall/flush controller; the stall-side counterpart to the EX/MEM operand forwarding unit.
- Covers hazards forwarding cannot resolve:
  - load-use dependency;
  - data-memory wait states;
  - multi-cycle divide;
  - taken-branch flush.
- Drives the stage register enables and bubble/flush controls of the 5-stage pipeline.
- Contains an FSM, a divide cycle counter and a deferred-flush register.

Parameters:
- REG_W, 5: register index width.
- DIV_CYCLES, 32: cycles a divide occupies EX, including the start cycle (≥2).
- CNT_W, 6: divide counter width (≥ clog2(DIV_CYCLES)+1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- rs_id  in  REG_W  ID-stage source register 1
- rt_id  in  REG_W  ID-stage source register 2
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_rd  in  REG_W  EX-stage destination register
- ex_is_load  in  1  EX instruction is a load
- ex_div_start  in  1  EX instruction is a divide (first cycle)
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_req  in  1  MEM instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC write enable
- ifid_en  out  1  IF/ID register enable
- idex_en  out  1  ID/EX register enable
- exmem_en  out  1  EX/MEM register enable
- memwb_en  out  1  MEM/WB register enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  load NOP into ID/EX
- div_done  out  1  pulse on last divide cycle
- hz_state  out  2  FSM state, for debug

Behaviour:
- States:
  - RUN = 0
  - MEM_WAIT = 1
  - DIV_BUSY = 2
  - Encoding 3 is illegal and returns to RUN next cycle.
- Registered elements: state, div_cnt[CNT_W], flush_pend. All outputs are combinational from these and the inputs.
- Reset (rst=1 at edge): state=RUN, div_cnt=0, flush_pend=0.
  - While rst is high, all enables=1, ifid_flush=0, idex_bubble=0, div_done=0, hz_state=0.
  - rst aborts MEM_WAIT/DIV_BUSY immediately; no div_done is issued.
- freeze = (state==MEM_WAIT) | (state==DIV_BUSY) | (state==RUN & mem_req & !mem_ready) | (state==RUN & ex_div_start).
- load_use = ex_is_load & ex_rd!=0 & ((id_uses_rs & rs_id==ex_rd) | (id_uses_rt & rt_id==ex_rd)).
- Priority is freeze > flush > load_use.
- freeze:
  - In MEM_WAIT: all five enables=0.
  - In DIV_BUSY, or RUN with ex_div_start: pc_en, ifid_en, idex_en, exmem_en=0 and memwb_en=1, so older instructions drain; MEM/WB then carries a bubble.
  - In RUN with mem_req & !mem_ready: all five enables=0.
  - In all freeze cases: ifid_flush=0, idex_bubble=0.
- flush (not frozen, ex_branch_taken | flush_pend):
  - ifid_flush=1 and idex_bubble=1; all enables=1.
  - load_use is ignored, since the ID instruction is killed.
  - flush_pend clears.
- load_use (not frozen, no flush):
  - pc_en=0, ifid_en=0, idex_bubble=1; other enables=1.
  - Exactly 1 stall cycle; the load then sits in MEM and the forwarding unit supplies the data.
- ex_branch_taken sampled while frozen sets flush_pend=1; the flush is applied on the first unfrozen cycle.
- FSM transitions:
  - RUN → MEM_WAIT when mem_req & !mem_ready.
  - RUN → DIV_BUSY when ex_div_start, with div_cnt←DIV_CYCLES-2.
  - If both hold, MEM_WAIT wins and ex_div_start is held in EX, so it is re-seen after the wait.
  - MEM_WAIT → RUN in the cycle mem_ready=1. Enables are still 0 that cycle; the pipeline advances the next cycle.
  - DIV_BUSY: div_cnt decrements each cycle. When div_cnt==0: div_done=1, all enables=1, → RUN.
  - mem_req during DIV_BUSY is not examined; MEM holds a bubble.
- A divide occupies exactly DIV_CYCLES cycles from the ex_div_start cycle to the div_done cycle inclusive.

Decomposition:
- Shared pipeline package holds:
  - REG_W;
  - state encoding constants HZ_RUN, HZ_MEM_WAIT, HZ_DIV_BUSY;
  - NOP encoding used by the flush/bubble logic elsewhere.
- One sub-module: hz_div_counter (load, decrement, zero flag), reusable by the divider datapath.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=8, rs_id=8, id_uses_rs=1 → 1 cycle with pc_en=0, ifid_en=0, idex_bubble=1; next cycle (ex_is_load=0) all enables=1.
- Zero register: same as above with ex_rd=0, rs_id=0 → no stall. Also rt_id=8 with id_uses_rt=0 → no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → all enables=0 for 4 cycles with hz_state=1 for 3 cycles; enables=1 on the 5th cycle.
- Divide, DIV_CYCLES=4: ex_div_start pulse → pc_en=0 for cycles 0–2, memwb_en=1 throughout, div_done=1 on cycle 3 only, hz_state returns to 0.
- Deferred flush: ex_branch_taken=1 during DIV_BUSY → no flush while busy; ifid_flush=1 and idex_bubble=1 on the first cycle after div_done.
- Reset mid-operation: rst=1 during MEM_WAIT → next cycle hz_state=0, all enables=1, flush_pend=0, div_done never asserted.
